// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared sizes and LOAD/RUN state encoding for the instruction-memory loader.
package imem_loader_pkg;
    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_AW    = 8;
    localparam int INST_W     = 9;
    localparam int CNT_W      = IMEM_AW + 1;
    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: 256x9 program store, synchronous write, asynchronous read.
module imem_ram
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [IMEM_AW-1:0] waddr,
    input  logic [INST_W-1:0]  wdata,
    input  logic [IMEM_AW-1:0] raddr,
    output logic [INST_W-1:0]  rdata
);
    logic [INST_W-1:0] mem [IMEM_DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program into imem_ram while holding the core in reset, then serves fetches.
// Optional IMEM_CHECKSUM_EN adds a running XOR of accepted words on port cksum.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [INST_W-1:0]  load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               reload,
    input  logic [IMEM_AW-1:0] pc,
    output logic [INST_W-1:0]  inst,
    output logic               core_rst,
    output logic [CNT_W-1:0]   word_count
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [INST_W-1:0]  cksum
`endif
);
    state_t state, state_nx;
    logic [IMEM_AW-1:0] wr_addr, last_addr;
    logic [CNT_W-1:0] cnt;
    logic [INST_W-1:0] rdata;
    logic hs, fin, restart;
    assign load_ready = state == LOAD && !rst;
    assign core_rst   = rst || state == LOAD;
    assign hs         = load_valid && load_ready;
    // The word at the top address ends the load even without load_last.
    assign fin        = hs && (load_last || wr_addr == '1);
    assign restart    = state == RUN && reload;
    assign word_count = rst ? '0 : cnt;
    assign inst       = (!rst && state == RUN && pc <= last_addr) ? rdata : '0;
    always_ff @(posedge clk)
        state <= rst ? LOAD : state_nx;
    always_comb begin
        state_nx = state;
        if (state == LOAD && fin) state_nx = RUN;
        if (restart) state_nx = LOAD;
    end
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            wr_addr <= '0;
            cnt     <= '0;
        end else if (hs) begin
            wr_addr <= wr_addr + IMEM_AW'(wr_addr != '1);
            cnt     <= cnt + CNT_W'(1);
        end
        if (rst) last_addr <= '0;
        else if (fin) last_addr <= wr_addr;
    end
`ifdef IMEM_CHECKSUM_EN
    always_ff @(posedge clk)
        if (rst || restart) cksum <= '0;
        else if (hs) cksum <= cksum ^ load_data;
`endif
    imem_ram u_ram (
        .clk   (clk),
        .we    (hs),
        .waddr (wr_addr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; fetch expectations are queued and checked by a separate monitor.
module tb_imem_loader;
    logic       clk = 0, rst = 0, load_valid = 0, load_last = 0, reload = 0;
    logic [8:0] load_data = 0;
    logic [7:0] pc = 0;
    logic       load_ready, core_rst;
    logic [8:0] inst, word_count;
`ifdef IMEM_CHECKSUM_EN
    logic [8:0] cksum;
`endif
    int ncmp = 0, nfail = 0;
    logic [8:0] mem_m [256];
    int n = 0;
    bit run = 0;
    logic [8:0] ck = 0;
    logic [8:0] q [$];
    bit fetch_req = 0;

    imem_loader dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .reload(reload), .pc(pc),
        .inst(inst), .core_rst(core_rst), .word_count(word_count)
`ifdef IMEM_CHECKSUM_EN
        , .cksum(cksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk)
        if (fetch_req) begin
            if (q.size() == 0) chk("scoreboard_empty", 1, 0);
            else chk("inst", {23'd0, inst}, {23'd0, q.pop_front()});
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] d, input bit last);
        load_valid = 1; load_data = d; load_last = last;
        chk("load_ready", {31'd0, load_ready}, 1);
        tick();
        mem_m[n] = d; n++; ck ^= d;
        if (last || n == 256) run = 1;
        load_valid = 0; load_data = 9'($urandom); load_last = 1'($urandom);
        chk("core_rst", {31'd0, core_rst}, {31'd0, !run});
    endtask

    task automatic idle();
        load_valid = 0; load_data = 9'($urandom); load_last = 1'($urandom);
        tick();
    endtask

    task automatic fetch(input int p);
        pc = 8'(p);
        q.push_back((run && p < n) ? mem_m[p] : 9'h000);
        fetch_req = 1;
        @(negedge clk);
        #1 fetch_req = 0;
    endtask

    task automatic do_reload();
        reload = 1;
        tick();
        reload = 0;
        if (run) begin n = 0; run = 0; ck = 0; end
        chk("reload_wc", {23'd0, word_count}, n);
        chk("reload_core_rst", {31'd0, core_rst}, {31'd0, !run});
    endtask

    task automatic do_reset(input bit with_valid);
        rst = 1; load_valid = with_valid; load_data = 9'h1AA; load_last = 1; reload = 1;
        #1;
        chk("rst_ready", {31'd0, load_ready}, 0);
        chk("rst_core_rst", {31'd0, core_rst}, 1);
        chk("rst_inst", {23'd0, inst}, 0);
        chk("rst_wc", {23'd0, word_count}, 0);
        tick();
        rst = 0; load_valid = 0; reload = 0;
        n = 0; run = 0; ck = 0;
        #1;
        chk("post_rst_wc", {23'd0, word_count}, 0);
        chk("post_rst_core_rst", {31'd0, core_rst}, 1);
        chk("post_rst_ready", {31'd0, load_ready}, 1);
    endtask

    initial begin
        tick();
        do_reset(0);
        send(9'h101, 0); send(9'h0A2, 0); send(9'h1FF, 1);
        chk("ready_after_last", {31'd0, load_ready}, 0);
        chk("wc3", {23'd0, word_count}, 3);
        fetch(1); fetch(3); fetch(0); fetch(2);
        load_valid = 1; load_data = 9'h033; tick(); load_valid = 0;
        chk("valid_ignored_in_run", {23'd0, word_count}, 3);
        do_reload();
        for (int i = 0; i < 256; i++) begin
            if (i < 255) chk("core_rst_during_256", {31'd0, core_rst}, 1);
            send(9'(i), 0);
        end
        chk("wc256", {23'd0, word_count}, 256);
        chk("ready_256", {31'd0, load_ready}, 0);
        fetch(255); fetch(0); fetch(128);
        do_reload();
        send(9'h055, 1);
        fetch(0); fetch(1); fetch(200);
        do_reload();
        send(9'h0C3, 0); idle(); send(9'h13C, 1);
        chk("toggle_wc", {23'd0, word_count}, 2);
        fetch(0); fetch(1); fetch(2);
        do_reload();
        send(9'h011, 0); send(9'h022, 0);
        do_reset(1);
        send(9'h0EE, 0); send(9'h0DD, 1);
        fetch(0); fetch(1); fetch(2); fetch(3);
        for (int r = 0; r < 6; r++) begin
            int len;
            if (run) do_reload();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) idle();
                if (i == 1) do_reload();
                send(9'($urandom), i == len - 1);
            end
            chk("rand_wc", {23'd0, word_count}, n);
            fetch(len - 1); fetch(len);
            for (int k = 0; k < 4; k++) fetch($urandom_range(0, 15));
        end
`ifdef IMEM_CHECKSUM_EN
        if (run) do_reload();
        send(9'h1F0, 0); send(9'h00F, 1);
        chk("cksum", {23'd0, cksum}, {23'd0, ck});
        chk("cksum_1ff", {23'd0, cksum}, 32'h1FF);
        do_reload();
        chk("cksum_cleared", {23'd0, cksum}, 0);
`endif
        tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
